// File: rtl/search_result_collector_if.sv
// search_result_collector_if
//   Bundles the search-side signals between the segment engine / TCAM top
//   (master) and the search result collector (slave).
//
//   Handshake: there is no backpressure. i_seg_valid qualifies i_seg_data
//   on every clock edge on which it is high, and the collector accepts it.
//   i_search_start and i_search_complete are single-cycle pulses.
//   o_result_valid is a single-cycle strobe; the result fields hold until
//   the next strobe and read 0 after a new search start.
//
//   Signals (master drives i_*, slave drives o_* and dbg_state):
//     i_search_start, i_search_key, i_seg_valid, i_seg_data,
//     i_search_complete, o_busy, o_result_valid, o_match, o_match_id,
//     o_match_priority, o_hit_count, o_overflow, dbg_state (FSM state),
//     o_stat_searches / o_stat_hits when COLLECTOR_STATS_EN is defined.
interface search_result_collector_if #(
    parameter int DATA_BITS = 10,
    parameter int IDWID     = 2,
    parameter int MASKWID   = 5,
    parameter int CNTWID    = 3
);
    localparam int KWID    = DATA_BITS;
    localparam int PRIOWID = IDWID;
    localparam int SEGWID  = 2 + IDWID + MASKWID + KWID + PRIOWID;

    logic                i_search_start;
    logic [KWID-1:0]     i_search_key;
    logic                i_seg_valid;
    logic [SEGWID-1:0]   i_seg_data;
    logic                i_search_complete;
    logic                o_busy;
    logic                o_result_valid;
    logic                o_match;
    logic [IDWID-1:0]    o_match_id;
    logic [PRIOWID-1:0]  o_match_priority;
    logic [CNTWID-1:0]   o_hit_count;
    logic                o_overflow;
    logic [1:0]          dbg_state;
`ifdef COLLECTOR_STATS_EN
    logic [15:0]         o_stat_searches;
    logic [15:0]         o_stat_hits;
`endif

    modport master (
        output i_search_start, i_search_key, i_seg_valid, i_seg_data,
               i_search_complete,
        input  o_busy, o_result_valid, o_match, o_match_id,
               o_match_priority, o_hit_count, o_overflow, dbg_state
`ifdef COLLECTOR_STATS_EN
        , input o_stat_searches, o_stat_hits
`endif
    );

    modport slave (
        input  i_search_start, i_search_key, i_seg_valid, i_seg_data,
               i_search_complete,
        output o_busy, o_result_valid, o_match, o_match_id,
               o_match_priority, o_hit_count, o_overflow, dbg_state
`ifdef COLLECTOR_STATS_EN
        , output o_stat_searches, o_stat_hits
`endif
    );
endinterface

// File: rtl/search_result_collector.sv
// search_result_collector
//   Captures segment words read back during a search, compares each stored
//   key against the search key under its per-fragment mask, keeps the
//   highest-priority live hit (earliest beat wins ties) and presents one
//   result two cycles after the engine signals search completion.
//
//   Ports: clk, reset (async, active-high), bus (search_result_collector_if
//   slave modport; see the interface header for the signal list).
//   Optional feature macro: COLLECTOR_STATS_EN adds 16-bit wrapping
//   o_stat_searches / o_stat_hits counters.
//
//   Pipeline: stage 1 registers the beat fields and its compare result,
//   stage 2 folds that into the best-hit registers.
module search_result_collector #(
    parameter int DATA_BITS = 10,
    parameter int FRAGMENTS = 5,
    parameter int IDWID     = 2,
    parameter int MASKWID   = 5,
    parameter int CNTWID    = 3
) (
    input logic                   clk,
    input logic                   reset,
    search_result_collector_if.slave bus
);
    localparam int KWID     = DATA_BITS;
    localparam int FRAG_WID = DATA_BITS / FRAGMENTS;
    localparam int PRIOWID  = IDWID;
    localparam int SEGWID   = 2 + IDWID + MASKWID + KWID + PRIOWID;

    typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, DONE} state_t;
    state_t state, state_next;

    // Segment fields, MSB to LSB: status, ID, MASK, KEY, PRIORITY.
    logic [1:0]         seg_status;
    logic [IDWID-1:0]   seg_id;
    logic [MASKWID-1:0] seg_mask;
    logic [KWID-1:0]    seg_key;
    logic [PRIOWID-1:0] seg_prio;
    assign seg_prio   = bus.i_seg_data[PRIOWID-1:0];
    assign seg_key    = bus.i_seg_data[PRIOWID +: KWID];
    assign seg_mask   = bus.i_seg_data[PRIOWID+KWID +: MASKWID];
    assign seg_id     = bus.i_seg_data[PRIOWID+KWID+MASKWID +: IDWID];
    assign seg_status = bus.i_seg_data[SEGWID-1 -: 2];

    logic [KWID-1:0] key_q;
    logic            frag_eq, seg_hit, accept;

    always_comb begin
        frag_eq = 1'b1;
        for (int i = 0; i < FRAGMENTS; i++) begin
            if (!seg_mask[i] &&
                seg_key[i*FRAG_WID +: FRAG_WID] != key_q[i*FRAG_WID +: FRAG_WID])
                frag_eq = 1'b0;
        end
    end
    assign seg_hit = (seg_status == 2'b10) && frag_eq;

    // A start pulse in COLLECT aborts, so a beat arriving with it is dropped.
    assign accept = (state == COLLECT) && bus.i_seg_valid && !bus.i_search_start;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.i_search_start) state_next = COLLECT;
            COLLECT: if (bus.i_search_start) state_next = COLLECT;
                     else if (bus.i_search_complete) state_next = DRAIN;
            DRAIN:   state_next = bus.i_search_start ? COLLECT : DONE;
            DONE:    state_next = bus.i_search_start ? COLLECT : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Stage 1 and stage 2 registers.
    logic               s1_valid, s1_hit;
    logic [IDWID-1:0]   s1_id;
    logic [PRIOWID-1:0] s1_prio;
    logic               best_valid, best_valid_next;
    logic [IDWID-1:0]   best_id, best_id_next;
    logic [PRIOWID-1:0] best_prio, best_prio_next;
    logic [CNTWID-1:0]  hit_cnt, hit_cnt_next, beat_cnt;
    logic               overflow;
    logic               res_match;
    logic [IDWID-1:0]   res_id;
    logic [PRIOWID-1:0] res_prio;
    logic [CNTWID-1:0]  res_hits;

    // Strictly-greater replaces, so equal priorities keep the earlier beat.
    always_comb begin
        best_valid_next = best_valid;
        best_id_next    = best_id;
        best_prio_next  = best_prio;
        hit_cnt_next    = hit_cnt;
        if (s1_valid && s1_hit) begin
            if (hit_cnt != {CNTWID{1'b1}}) hit_cnt_next = hit_cnt + 1'b1;
            if (!best_valid || s1_prio > best_prio) begin
                best_valid_next = 1'b1;
                best_id_next    = s1_id;
                best_prio_next  = s1_prio;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_q <= '0; s1_valid <= 1'b0; s1_hit <= 1'b0; s1_id <= '0; s1_prio <= '0;
            best_valid <= 1'b0; best_id <= '0; best_prio <= '0;
            hit_cnt <= '0; beat_cnt <= '0; overflow <= 1'b0;
            res_match <= 1'b0; res_id <= '0; res_prio <= '0; res_hits <= '0;
        end else if (bus.i_search_start) begin
            key_q <= bus.i_search_key; s1_valid <= 1'b0; s1_hit <= 1'b0;
            s1_id <= '0; s1_prio <= '0;
            best_valid <= 1'b0; best_id <= '0; best_prio <= '0;
            hit_cnt <= '0; beat_cnt <= '0; overflow <= 1'b0;
            res_match <= 1'b0; res_id <= '0; res_prio <= '0; res_hits <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_hit  <= seg_hit;
                s1_id   <= seg_id;
                s1_prio <= seg_prio;
                if (beat_cnt != {CNTWID{1'b1}}) beat_cnt <= beat_cnt + 1'b1;
                if (beat_cnt >= CNTWID'(FRAGMENTS)) overflow <= 1'b1;
            end
            best_valid <= best_valid_next;
            best_id    <= best_id_next;
            best_prio  <= best_prio_next;
            hit_cnt    <= hit_cnt_next;
            // DRAIN is the last stage-2 update; capture its outcome for DONE.
            if (state == DRAIN) begin
                res_match <= best_valid_next;
                res_id    <= best_id_next;
                res_prio  <= best_prio_next;
                res_hits  <= hit_cnt_next;
            end
        end
    end

    assign bus.o_busy           = (state != IDLE);
    assign bus.o_result_valid   = (state == DONE);
    assign bus.o_match          = res_match;
    assign bus.o_match_id       = res_id;
    assign bus.o_match_priority = res_prio;
    assign bus.o_hit_count      = res_hits;
    assign bus.o_overflow       = overflow;
    assign bus.dbg_state        = state;

`ifdef COLLECTOR_STATS_EN
    logic [15:0] stat_searches, stat_hits;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_searches <= '0;
            stat_hits     <= '0;
        end else if (state == DONE) begin
            stat_searches <= stat_searches + 16'd1;
            if (res_match) stat_hits <= stat_hits + 16'd1;
        end
    end
    assign bus.o_stat_searches = stat_searches;
    assign bus.o_stat_hits     = stat_hits;
`else
    // Statistics counters are not built in this configuration.
`endif
endmodule

// File: tb/tb_search_result_collector.sv
// tb_search_result_collector
//   Directed test of search_result_collector: exact hit, masked/dead
//   entries, priority ties, overflow/no-match, abort, hit-count saturation,
//   beat coincident with complete, start during DONE and reset mid-search.
module tb_search_result_collector;
    localparam int DATA_BITS = 10;
    localparam int FRAGMENTS = 5;
    localparam int IDWID     = 2;
    localparam int MASKWID   = 5;
    localparam int CNTWID    = 3;
    localparam int SEGWID    = 2 + IDWID + MASKWID + DATA_BITS + IDWID;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   rv_count;
    int   rv_mark;
    int   exp_searches;
    int   exp_hits;

    search_result_collector_if #(
        .DATA_BITS(DATA_BITS), .IDWID(IDWID), .MASKWID(MASKWID), .CNTWID(CNTWID)
    ) bus ();

    search_result_collector #(
        .DATA_BITS(DATA_BITS), .FRAGMENTS(FRAGMENTS), .IDWID(IDWID),
        .MASKWID(MASKWID), .CNTWID(CNTWID)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Result strobes counted away from the active edge.
    always @(negedge clk) if (bus.o_result_valid === 1'b1) rv_count++;

    function automatic logic [SEGWID-1:0] mkseg(input logic [1:0] st,
        input logic [1:0] id, input logic [4:0] mask, input logic [9:0] key,
        input logic [1:0] prio);
        return {st, id, mask, key, prio};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [9:0] key);
        bus.i_search_start = 1'b1;
        bus.i_search_key   = key;
        tick();
        bus.i_search_start = 1'b0;
    endtask

    task automatic beat(input logic [SEGWID-1:0] seg);
        bus.i_seg_valid = 1'b1;
        bus.i_seg_data  = seg;
        tick();
        bus.i_seg_valid = 1'b0;
    endtask

    // Complete pulse, then check the result two cycles later.
    task automatic finish(input string tag, input logic m, input logic [1:0] id,
                          input logic [1:0] prio, input logic [2:0] hits,
                          input logic ovf);
        bus.i_search_complete = 1'b1;
        tick();
        bus.i_search_complete = 1'b0;
        check({tag, "_drain_rv"}, 32'(bus.o_result_valid), 32'd0);
        tick();
        check({tag, "_rv"},    32'(bus.o_result_valid), 32'd1);
        check({tag, "_busy"},  32'(bus.o_busy), 32'd1);
        check({tag, "_match"}, 32'(bus.o_match), 32'(m));
        check({tag, "_id"},    32'(bus.o_match_id), 32'(id));
        check({tag, "_prio"},  32'(bus.o_match_priority), 32'(prio));
        check({tag, "_hits"},  32'(bus.o_hit_count), 32'(hits));
        check({tag, "_ovf"},   32'(bus.o_overflow), 32'(ovf));
        exp_searches++;
        if (m) exp_hits++;
    endtask

    initial begin
        checks = 0; errors = 0; rv_count = 0; exp_searches = 0; exp_hits = 0;
        reset = 1'b1;
        bus.i_search_start = 1'b0; bus.i_search_key = '0;
        bus.i_seg_valid = 1'b0; bus.i_seg_data = '0; bus.i_search_complete = 1'b0;
        tick(); tick();
        check("rst_busy",  32'(bus.o_busy), 32'd0);
        check("rst_rv",    32'(bus.o_result_valid), 32'd0);
        check("rst_match", 32'(bus.o_match), 32'd0);
        check("rst_hits",  32'(bus.o_hit_count), 32'd0);
        check("rst_state", 32'(bus.dbg_state), 32'd0);
        reset = 1'b0;
        tick();

        // Complete in IDLE is ignored.
        bus.i_search_complete = 1'b1; tick(); bus.i_search_complete = 1'b0;
        tick(); tick();
        check("idle_cmpl_rv", 32'(rv_count), 32'd0);
        check("idle_cmpl_state", 32'(bus.dbg_state), 32'd0);

        // Exact hit.
        start(10'h2A5);
        check("t1_busy", 32'(bus.o_busy), 32'd1);
        beat(mkseg(2'b10, 2'd1, 5'b00000, 10'h2A5, 2'd2));
        finish("t1", 1'b1, 2'd1, 2'd2, 3'd1, 1'b0);
        tick();
        check("t1_idle_rv", 32'(bus.o_result_valid), 32'd0);
        check("t1_idle_busy", 32'(bus.o_busy), 32'd0);
        check("t1_hold_match", 32'(bus.o_match), 32'd1);

        // Masked live entry hits; dead entry never hits.
        start(10'h3FF);
        check("t2_cleared", 32'(bus.o_match), 32'd0);
        beat(mkseg(2'b10, 2'd2, 5'b00001, 10'h3FC, 2'd1));
        beat(mkseg(2'b11, 2'd3, 5'b00000, 10'h3FF, 2'd3));
        finish("t2", 1'b1, 2'd2, 2'd1, 3'd1, 1'b0);
        tick();

        // Priority and tie: earlier beat keeps an equal priority.
        start(10'h12C);
        beat(mkseg(2'b10, 2'd0, 5'b00000, 10'h12C, 2'd1));
        beat(mkseg(2'b10, 2'd1, 5'b00000, 10'h12C, 2'd3));
        beat(mkseg(2'b10, 2'd2, 5'b00000, 10'h12C, 2'd3));
        beat(mkseg(2'b10, 2'd3, 5'b00000, 10'h12C, 2'd0));
        beat(mkseg(2'b10, 2'd0, 5'b00000, 10'h12C, 2'd2));
        finish("t3", 1'b1, 2'd1, 2'd3, 3'd5, 1'b0);
        tick();

        // Overflow with no match: every fragment of 0AA differs from 155.
        start(10'h155);
        for (int i = 0; i < 5; i++)
            beat(mkseg(2'b10, 2'(i), 5'b00000, 10'h0AA, 2'd3));
        check("t4_no_ovf_yet", 32'(bus.o_overflow), 32'd0);
        beat(mkseg(2'b10, 2'd1, 5'b11110, 10'h0AA, 2'd3));
        finish("t4", 1'b0, 2'd0, 2'd0, 3'd0, 1'b1);
        tick();

        // Abort: two hits then a restart with no beats.
        rv_mark = rv_count;
        start(10'h2A5);
        beat(mkseg(2'b10, 2'd1, 5'b00000, 10'h2A5, 2'd2));
        beat(mkseg(2'b10, 2'd2, 5'b00000, 10'h2A5, 2'd3));
        start(10'h001);
        check("t5_busy", 32'(bus.o_busy), 32'd1);
        finish("t5", 1'b0, 2'd0, 2'd0, 3'd0, 1'b0);
        tick(); tick();
        check("t5_one_rv", 32'(rv_count - rv_mark), 32'd1);

        // Hit count saturates at 7; all ties, so the first beat (ID 3) wins.
        start(10'h0F0);
        beat(mkseg(2'b10, 2'd3, 5'b00000, 10'h0F0, 2'd0));
        for (int i = 0; i < 7; i++)
            beat(mkseg(2'b10, 2'd0, 5'b11111, 10'h000, 2'd0));
        finish("t6", 1'b1, 2'd3, 2'd0, 3'd7, 1'b1);
        tick();

        // Beat in the same cycle as complete is included.
        start(10'h1C3);
        beat(mkseg(2'b10, 2'd1, 5'b00000, 10'h1C3, 2'd1));
        bus.i_seg_valid = 1'b1;
        bus.i_seg_data  = mkseg(2'b10, 2'd2, 5'b00000, 10'h1C3, 2'd2);
        finish("t7", 1'b1, 2'd2, 2'd2, 3'd2, 1'b0);
        bus.i_seg_valid = 1'b0;
        tick();

        // Start during DONE: result emitted, next state COLLECT.
        start(10'h033);
        beat(mkseg(2'b10, 2'd3, 5'b00000, 10'h033, 2'd1));
        bus.i_search_complete = 1'b1; tick(); bus.i_search_complete = 1'b0;
        tick();
        check("t8_rv", 32'(bus.o_result_valid), 32'd1);
        check("t8_match", 32'(bus.o_match), 32'd1);
        check("t8_id", 32'(bus.o_match_id), 32'd3);
        exp_searches++; exp_hits++;
        start(10'h200);
        check("t8_state", 32'(bus.dbg_state), 32'd1);
        check("t8_busy", 32'(bus.o_busy), 32'd1);
        check("t8_cleared", 32'(bus.o_match), 32'd0);
        beat(mkseg(2'b10, 2'd0, 5'b00000, 10'h200, 2'd3));
        finish("t8b", 1'b1, 2'd0, 2'd3, 3'd1, 1'b0);
        tick();

`ifdef COLLECTOR_STATS_EN
        check("stat_searches", 32'(bus.o_stat_searches), 32'(exp_searches));
        check("stat_hits", 32'(bus.o_stat_hits), 32'(exp_hits));
`endif

        // Reset mid-collect: no result, everything back to 0.
        rv_mark = rv_count;
        start(10'h2A5);
        beat(mkseg(2'b10, 2'd1, 5'b00000, 10'h2A5, 2'd2));
        reset = 1'b1; tick(); reset = 1'b0;
        bus.i_search_complete = 1'b1; tick(); bus.i_search_complete = 1'b0;
        tick(); tick(); tick();
        check("t9_no_rv", 32'(rv_count - rv_mark), 32'd0);
        check("t9_busy", 32'(bus.o_busy), 32'd0);
        check("t9_match", 32'(bus.o_match), 32'd0);
        check("t9_id", 32'(bus.o_match_id), 32'd0);
        check("t9_prio", 32'(bus.o_match_priority), 32'd0);
        check("t9_hits", 32'(bus.o_hit_count), 32'd0);
        check("t9_ovf", 32'(bus.o_overflow), 32'd0);
        check("t9_state", 32'(bus.dbg_state), 32'd0);
`ifdef COLLECTOR_STATS_EN
        check("t9_stat_searches", 32'(bus.o_stat_searches), 32'd0);
        check("t9_stat_hits", 32'(bus.o_stat_hits), 32'd0);
`endif

        // Final report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
